// File: rtl/sram_byte_stream.sv
// Byte-wide streaming port onto a single 1rw SRAM macro. A command-loaded byte pointer
// selects word and lane; reads land in a held output register two edges after issue.
module sram_byte_stream #(
    parameter int WORD_BYTES = 4,
    parameter int ADDR_W     = 9
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    ena,
    input  logic [7:0]              ui_in,
    input  logic [7:0]              uio_in,
    output logic [7:0]              uo_out,
    output logic [7:0]              uio_out,
    output logic [7:0]              uio_oe,
    output logic                    ram_clk0,
    output logic                    ram_csb0,
    output logic                    ram_web0,
    output logic [WORD_BYTES-1:0]   ram_wmask0,
    output logic [ADDR_W-1:0]       ram_addr0,
    output logic [8*WORD_BYTES-1:0] ram_din0,
    input  logic [8*WORD_BYTES-1:0] ram_dout0
);
    localparam int LANE_W = $clog2(WORD_BYTES);
    localparam int SEL_W  = (LANE_W > 0) ? LANE_W : 1;
    localparam int PTR_W  = ADDR_W + LANE_W;

    localparam logic [1:0] CMD_RD = 2'b00;
    localparam logic [1:0] CMD_WR = 2'b01;
    localparam logic [1:0] CMD_LO = 2'b10;

    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [7:0]       data_q, data_d;
    logic             rd_pend_q, rd_pend_d;

    logic [1:0]       cmd;
    logic             issue;
    logic [SEL_W-1:0] lane;
    logic [7:0]       rd_byte;
    logic             unused_bits;

    assign cmd         = ui_in[7:6];
    // rst_n gates issue so the array is never selected while reset is held
    assign issue       = ui_in[5] & ena & rst_n;
    assign unused_bits = ^ui_in[3:0];

    generate
        if (LANE_W > 0) begin : g_lane
            assign lane = ptr_q[LANE_W-1:0];
        end else begin : g_no_lane
            assign lane = '0;
        end
    endgenerate

    assign ram_clk0  = clk;
    assign ram_addr0 = ptr_q[PTR_W-1 -: ADDR_W];
    assign ram_din0  = {WORD_BYTES{uio_in}};
    assign uo_out    = data_q;
    assign uio_out   = 8'h00;
    assign uio_oe    = 8'h00;

    always_comb begin
        rd_byte = 8'h00;
        for (int i = 0; i < WORD_BYTES; i++) begin
            if (sel_q == SEL_W'(i)) rd_byte = ram_dout0[8*i +: 8];
        end
    end

    always_comb begin
        ram_csb0   = 1'b1;
        ram_web0   = 1'b1;
        ram_wmask0 = '0;
        ptr_d      = ptr_q;
        sel_d      = sel_q;
        rd_pend_d  = 1'b0;
        // a capture pending from the previous edge completes whatever is issued now
        data_d     = rd_pend_q ? rd_byte : data_q;
        if (issue) begin
            case (cmd)
                CMD_RD: begin
                    ram_csb0  = 1'b0;
                    sel_d     = lane;
                    rd_pend_d = 1'b1;
                    if (ui_in[4]) ptr_d = ptr_q + PTR_W'(1);
                end
                CMD_WR: begin
                    ram_csb0   = 1'b0;
                    ram_web0   = 1'b0;
                    ram_wmask0 = WORD_BYTES'(1) << lane;
                    if (ui_in[4]) ptr_d = ptr_q + PTR_W'(1);
                end
                CMD_LO: ptr_d[7:0] = uio_in;
                default: ptr_d[PTR_W-1:8] = uio_in[PTR_W-9:0];
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q     <= '0;
            sel_q     <= '0;
            data_q    <= 8'h00;
            rd_pend_q <= 1'b0;
        end else begin
            ptr_q     <= ptr_d;
            sel_q     <= sel_d;
            data_q    <= data_d;
            rd_pend_q <= rd_pend_d;
        end
    end

endmodule

// File: tb/tb_sram_byte_stream.sv
// Directed bench for sram_byte_stream with a behavioural 1rw SRAM (512 x 32) attached.
module tb_sram_byte_stream;
    localparam int WB = 4;
    localparam int AW = 9;
    localparam logic [1:0] RD = 2'b00, WR = 2'b01, LO = 2'b10, HI = 2'b11;

    logic          clk = 1'b0;
    logic          rst_n, ena;
    logic [7:0]    ui_in, uio_in, uo_out, uio_out, uio_oe;
    logic          ram_clk0, ram_csb0, ram_web0;
    logic [WB-1:0] ram_wmask0;
    logic [AW-1:0] ram_addr0;
    logic [8*WB-1:0] ram_din0, ram_dout0;

    logic [31:0] mem [0:(1<<AW)-1];
    int n_vec = 0;
    int n_err = 0;

    sram_byte_stream #(.WORD_BYTES(WB), .ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
        .uo_out(uo_out), .uio_out(uio_out), .uio_oe(uio_oe),
        .ram_clk0(ram_clk0), .ram_csb0(ram_csb0), .ram_web0(ram_web0),
        .ram_wmask0(ram_wmask0), .ram_addr0(ram_addr0), .ram_din0(ram_din0),
        .ram_dout0(ram_dout0)
    );

    always #5 clk = ~clk;

    always @(posedge ram_clk0) begin
        if (!ram_csb0) begin
            if (!ram_web0) begin
                for (int b = 0; b < WB; b++)
                    if (ram_wmask0[b]) mem[ram_addr0][8*b +: 8] <= ram_din0[8*b +: 8];
            end else begin
                ram_dout0 <= mem[ram_addr0];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [1:0] c, input logic go, input logic ai, input logic [7:0] d);
        ui_in  = {c, go, ai, 4'b0000};
        uio_in = d;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(RD, 1'b0, 1'b0, 8'h00);
        tick();
    endtask

    task automatic load_ptr(input logic [15:0] p);
        drive(LO, 1'b1, 1'b0, p[7:0]);
        tick();
        drive(HI, 1'b1, 1'b0, p[15:8]);
        tick();
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = 32'h0;
        ram_dout0 = '0;
        rst_n = 1'b0; ena = 1'b1;
        ui_in = 8'h00; uio_in = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_uo_out", 32'(uo_out), 32'h00);
        chk("rst_csb", 32'(ram_csb0), 32'h1);
        chk("rst_uio_oe", 32'(uio_oe), 32'h00);
        chk("rst_uio_out", 32'(uio_out), 32'h00);
        drive(WR, 1'b1, 1'b0, 8'hFF);
        chk("rst_gate_csb", 32'(ram_csb0), 32'h1);
        chk("rst_gate_web", 32'(ram_web0), 32'h1);
        chk("rst_gate_wmask", 32'(ram_wmask0), 32'h0);
        rst_n = 1'b1;
        idle();
        chk("idle_uo_out", 32'(uo_out), 32'h00);
        chk("idle_csb", 32'(ram_csb0), 32'h1);

        drive(LO, 1'b1, 1'b0, 8'h12);
        chk("load_lo_csb", 32'(ram_csb0), 32'h1);
        tick();
        drive(HI, 1'b1, 1'b1, 8'h05);
        chk("load_hi_csb", 32'(ram_csb0), 32'h1);
        tick();
        drive(RD, 1'b0, 1'b0, 8'h00);
        chk("load_addr", 32'(ram_addr0), 32'h144);

        // streaming writes 0xA0..0xA7 from ptr 0
        load_ptr(16'h0000);
        for (int i = 0; i < 8; i++) begin
            drive(WR, 1'b1, 1'b1, 8'(8'hA0 + i));
            chk($sformatf("wr%0d_wmask", i), 32'(ram_wmask0), 32'(1 << (i % 4)));
            chk($sformatf("wr%0d_addr", i), 32'(ram_addr0), 32'(i / 4));
            chk($sformatf("wr%0d_csb_web", i), {30'b0, ram_csb0, ram_web0}, 32'h0);
            chk($sformatf("wr%0d_din", i), 32'(ram_din0), {4{8'(8'hA0 + i)}});
            tick();
        end

        // back-to-back reads, output trails issue by two edges
        load_ptr(16'h0000);
        for (int i = 0; i < 8; i++) begin
            drive(RD, 1'b1, 1'b1, 8'h00);
            chk($sformatf("rd%0d_addr", i), 32'(ram_addr0), 32'(i / 4));
            chk($sformatf("rd%0d_ctl", i), {28'b0, ram_csb0, ram_web0, 2'b00} | 32'(ram_wmask0), 32'h4);
            tick();
            chk($sformatf("rd%0d_uo_out", i), 32'(uo_out), (i == 0) ? 32'h00 : 32'(8'hA0 + i - 1));
        end
        idle();
        chk("rd_last_uo_out", 32'(uo_out), 32'hA7);
        idle();
        chk("rd_hold_uo_out", 32'(uo_out), 32'hA7);

        // write right after a read keeps that read's capture
        load_ptr(16'h0001);
        drive(RD, 1'b1, 1'b0, 8'h00);
        tick();
        drive(WR, 1'b1, 1'b0, 8'hB1);
        chk("rw_wmask", 32'(ram_wmask0), 32'h2);
        tick();
        chk("rw_capture", 32'(uo_out), 32'hA1);
        drive(RD, 1'b1, 1'b0, 8'h00);
        tick();
        idle();
        chk("rw_new_value", 32'(uo_out), 32'hB1);

        // pointer wrap at 0x7FF
        load_ptr(16'h07FF);
        drive(WR, 1'b1, 1'b1, 8'h5A);
        chk("wrap_wr_addr", 32'(ram_addr0), 32'h1FF);
        chk("wrap_wr_wmask", 32'(ram_wmask0), 32'h8);
        tick();
        drive(RD, 1'b1, 1'b0, 8'h00);
        chk("wrap_ptr_addr", 32'(ram_addr0), 32'h000);
        tick();
        idle();
        chk("wrap_rd_uo_out", 32'(uo_out), 32'hA0);
        load_ptr(16'h07FF);
        drive(RD, 1'b1, 1'b0, 8'h00);
        tick();
        idle();
        chk("wrap_wr_landed", 32'(uo_out), 32'h5A);

        // ena low blocks issue
        ena = 1'b0;
        drive(RD, 1'b1, 1'b1, 8'h00);
        chk("ena0_csb", 32'(ram_csb0), 32'h1);
        tick();
        ena = 1'b1;
        drive(RD, 1'b0, 1'b0, 8'h00);
        chk("ena0_addr", 32'(ram_addr0), 32'h1FF);
        chk("ena0_uo_out", 32'(uo_out), 32'h5A);
        drive(RD, 1'b1, 1'b0, 8'h00);
        tick();
        idle();
        chk("ena0_ptr_lane", 32'(uo_out), 32'h5A);

        // reset while a capture is pending
        load_ptr(16'h0203);
        drive(RD, 1'b1, 1'b0, 8'h00);
        tick();
        rst_n = 1'b0;
        #1;
        chk("rstp_uo_out", 32'(uo_out), 32'h00);
        chk("rstp_addr", 32'(ram_addr0), 32'h000);
        chk("rstp_csb", 32'(ram_csb0), 32'h1);
        tick();
        chk("rstp_held_uo_out", 32'(uo_out), 32'h00);
        rst_n = 1'b1;
        load_ptr(16'h0003);
        drive(RD, 1'b1, 1'b0, 8'h00);
        tick();
        idle();
        chk("rstp_after_read", 32'(uo_out), 32'hA3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/sram_byte_stream.md
Name: sram_byte_stream

Overview:
- Parametrised byte-wide access port onto a single 1rw SRAM macro (the OpenRAM-style ram_* interface).
- Successor to the direct-address SRAM test wrapper: holds an internal byte pointer loaded by command, with optional auto-increment for streaming reads and writes.
- Read data is registered and held, so uo_out stays stable between reads.
- Chip select is asserted only on cycles that access the array.

Parameters:
- WORD_BYTES, 4, bytes per SRAM word; power of two, 1..4.
- ADDR_W, 9, SRAM word-address width.
- PTR_W is derived as ADDR_W + clog2(WORD_BYTES). Constraint: 9 <= PTR_W <= 16.

Ports:
- clk  in  1  system clock; also drives ram_clk0.
- rst_n  in  1  asynchronous active-low reset.
- ena  in  1  design enable; when low, no command executes.
- ui_in  in  8  [7:6] cmd (00 read, 01 write, 10 load ptr low, 11 load ptr high); [5] go strobe; [4] autoinc; [3:0] unused.
- uio_in  in  8  write data, or pointer load value.
- uo_out  out  8  last read byte, held.
- uio_out  out  8  constant 0.
- uio_oe  out  8  constant 0 (all inputs).
- ram_clk0  out  1  = clk.
- ram_csb0  out  1  active-low chip select.
- ram_web0  out  1  active-low write enable.
- ram_wmask0  out  WORD_BYTES  byte write mask.
- ram_addr0  out  ADDR_W  word address = ptr[PTR_W-1:PTR_W-ADDR_W].
- ram_din0  out  8*WORD_BYTES  uio_in replicated into every byte lane.
- ram_dout0  in  8*WORD_BYTES  SRAM read data, valid after the clk edge that sampled the address.

Behaviour:
Command issue
- A command executes on a rising edge when go && ena && rst_n.
- ram_* signals are combinational from ui_in, uio_in and ptr, so the SRAM samples them on the same edge.
- lane = ptr[clog2(WORD_BYTES)-1:0]; lane is 0 when WORD_BYTES = 1.

Read (00)
- ram_csb0 = 0, ram_web0 = 1, ram_wmask0 = 0.
- At edge N: sel_q <= lane and rd_pend <= 1.
- At edge N+1, if rd_pend: data_q <= ram_dout0[8*sel_q +: 8].
- uo_out = data_q. Read latency is 2 edges from issue to uo_out update.

Write (01)
- ram_csb0 = 0, ram_web0 = 0, ram_wmask0 = one-hot(lane).
- data_q is unchanged.

Read pipelining
- rd_pend <= 1 on every read issue, otherwise 0.
- Back-to-back reads give one capture per cycle.
- A write in the cycle after a read does not block that read's capture.

Load pointer
- 10: ptr[7:0] <= uio_in; upper bits unchanged.
- 11: ptr[PTR_W-1:8] <= uio_in[PTR_W-9:0]; lower bits unchanged.
- ram_csb0 = 1 for both; autoinc is ignored.

Auto-increment
- Applies after a read or write when ui_in[4] = 1: ptr <= ptr + 1 mod 2^PTR_W.
- Wrap from all-ones to 0 is silent.
- Lane crossing advances to the next word.

Idle
- Idle cycles (go = 0 or ena = 0): ram_csb0 = 1, ram_web0 = 1, ram_wmask0 = 0; no register changes except rd_pend <= 0. A capture already pending still completes.

Reset
- Asynchronous assertion: ptr = 0, sel_q = 0, data_q = 0, rd_pend = 0.
- While rst_n = 0: ram_csb0 = 1, ram_web0 = 1, ram_wmask0 = 0.
- Reset during a pending read drops the capture; uo_out reads 0.
- Release is synchronous in effect: the first command executes on the first edge with rst_n = 1.

Write to the same byte just read
- The next read returns the new value; no bypass is needed because reads go to the array.

Test Plan:
- Reset, then idle -> uo_out = 0x00, ram_csb0 = 1, uio_oe = 0x00; load-low 0x12 and load-high 0x05 -> ram_addr0 = 0x144 (ptr = 0x512).
- ptr = 0, autoinc writes of 0xA0..0xA7 -> wmask sequence 1, 2, 4, 8, 1, 2, 4, 8; ram_addr0 0, 0, 0, 0, 1, 1, 1, 1.
- ptr = 0, 8 back-to-back autoinc reads -> uo_out shows 0xA0..0xA7 on consecutive cycles, starting 2 edges after the first issue.
- ptr = 0x7FF (PTR_W = 11), autoinc write 0x5A, then read at ptr = 0 -> ptr wraps to 0x000; the read does not return 0x5A.
- Read issued with go = 1, ena = 0 -> ram_csb0 = 1, ptr and uo_out unchanged.
- Issue a read, assert rst_n = 0 before the capture edge -> uo_out = 0x00 and ptr = 0 immediately; after release, a read at 0x003 returns 0xA3.
